// File: rtl/nyq_seq_ctrl.sv
// Sequencer for the polyphase Nyquist decimator: phase counting, per-lane coefficient addresses,
// MAC/chain strobes and output handshake. Optional frame counter under NYQ_CTRL_FRAMECNT_EN.
module nyq_seq_ctrl #(
  parameter int unsigned CNT_WIDTH  = 3,
  parameter int unsigned NUM_MAC    = 4,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                          Clk_CI,
  input  logic                          Rst_RBI,
  input  logic                          En_SI,
  input  logic [CNT_WIDTH-1:0]          Decim_DI,
  input  logic                          InValid_SI,
  output logic                          InReady_SO,
  output logic [NUM_MAC*ADDR_WIDTH-1:0] CoefAddr_DO,
  output logic                          MacEn_SO,
  output logic                          MacClr_SO,
  output logic                          ChainEn_SO,
  output logic                          OutValid_SO,
  input  logic                          OutReady_SI,
  output logic [15:0]                   FrameCnt_DO
);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDump
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] phase_q, phase_d;
  logic [CNT_WIDTH-1:0] d_q, d_d;
  logic                 out_pend_q, out_pend_d;

  logic                 in_ready;
  logic                 accept;
  logic                 chain_en;
  logic [CNT_WIDTH-1:0] d_sel;
  logic [CNT_WIDTH-1:0] phase_sel;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      d_q        <= '0;
      out_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      d_q        <= d_d;
      out_pend_q <= out_pend_d;
    end
  end

  // Ready is gated by reset so every strobe reads as idle while reset is held.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    d_d       = d_q;
    in_ready  = 1'b0;
    MacEn_SO  = 1'b0;
    MacClr_SO = 1'b0;
    chain_en  = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = En_SI & Rst_RBI;
        accept   = InValid_SI & in_ready;
        if (accept) begin
          MacEn_SO  = 1'b1;
          MacClr_SO = 1'b1;
          d_d       = Decim_DI;
          if (Decim_DI == '0) begin
            state_d = StDump;
          end else begin
            state_d = StAccum;
            phase_d = CNT_WIDTH'(1);
          end
        end
      end
      StAccum: begin
        in_ready = En_SI & Rst_RBI;
        accept   = InValid_SI & in_ready;
        if (!En_SI) begin
          // Abort: drop the partial frame without touching a pending output.
          state_d = StIdle;
          phase_d = '0;
        end else if (accept) begin
          MacEn_SO = 1'b1;
          if (phase_q == d_q) begin
            state_d = StDump;
          end else begin
            phase_d = phase_q + CNT_WIDTH'(1);
          end
        end
      end
      StDump: begin
        if (!(out_pend_q && !OutReady_SI)) begin
          chain_en = 1'b1;
          phase_d  = '0;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        phase_d = '0;
      end
    endcase
  end

  always_comb begin
    out_pend_d = out_pend_q;
    if (chain_en) begin
      out_pend_d = 1'b1;
    end else if (out_pend_q && OutReady_SI) begin
      out_pend_d = 1'b0;
    end
  end

  assign InReady_SO  = in_ready;
  assign ChainEn_SO  = chain_en;
  assign OutValid_SO = out_pend_q;

  // In idle the first sample of the next frame uses the live decimation factor at phase 0.
  always_comb begin
    d_sel       = '0;
    phase_sel   = '0;
    CoefAddr_DO = '0;
    if (Rst_RBI) begin
      if (state_q == StIdle) begin
        d_sel = Decim_DI;
      end else begin
        d_sel     = d_q;
        phase_sel = phase_q;
      end
    end
    for (int unsigned k = 0; k < NUM_MAC; k++) begin
      CoefAddr_DO[k*ADDR_WIDTH +: ADDR_WIDTH] =
          ADDR_WIDTH'(k) * (ADDR_WIDTH'(d_sel) + ADDR_WIDTH'(1)) + ADDR_WIDTH'(phase_sel);
    end
  end

`ifdef NYQ_CTRL_FRAMECNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      frame_cnt_q <= '0;
    end else if (chain_en) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign FrameCnt_DO = frame_cnt_q;
`else
  assign FrameCnt_DO = '0;
`endif

endmodule

// File: tb/tb_nyq_seq_ctrl.sv
// Directed + randomized bench for nyq_seq_ctrl against a sample-counting frame model.
module tb_nyq_seq_ctrl;

  localparam int unsigned CW = 3;
  localparam int unsigned NM = 4;
  localparam int unsigned AW = 9;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [CW-1:0]  decim;
  logic           valid;
  logic           in_ready;
  logic [NM*AW-1:0] coef_addr;
  logic           mac_en;
  logic           mac_clr;
  logic           chain_en;
  logic           out_valid;
  logic           out_ready;
  logic [15:0]    frame_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: samples taken in the current frame, latched factor, waiting-to-dump, pending output.
  int m_cnt;
  int m_d;
  bit m_dump;
  bit m_pend;
  int m_frames;
  bit e_acc;
  bit e_chain;

  nyq_seq_ctrl #(
    .CNT_WIDTH (CW),
    .NUM_MAC   (NM),
    .ADDR_WIDTH(AW)
  ) dut (
    .Clk_CI     (clk),
    .Rst_RBI    (rst_n),
    .En_SI      (en),
    .Decim_DI   (decim),
    .InValid_SI (valid),
    .InReady_SO (in_ready),
    .CoefAddr_DO(coef_addr),
    .MacEn_SO   (mac_en),
    .MacClr_SO  (mac_clr),
    .ChainEn_SO (chain_en),
    .OutValid_SO(out_valid),
    .OutReady_SI(out_ready),
    .FrameCnt_DO(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_d      = 0;
    m_dump   = 0;
    m_pend   = 0;
    m_frames = 0;
  endtask

  task automatic check(input string tag);
    bit ready;
    int d;
    int ph;
    if (m_dump) begin
      ready   = 0;
      e_chain = !(m_pend && !out_ready);
    end else begin
      ready   = en && rst_n;
      e_chain = 0;
    end
    e_acc = ready && valid;
    cmp({tag, ".in_ready"}, 32'(in_ready), 32'(ready));
    cmp({tag, ".mac_en"}, 32'(mac_en), 32'(e_acc));
    cmp({tag, ".mac_clr"}, 32'(mac_clr), 32'(e_acc && m_cnt == 0));
    cmp({tag, ".chain_en"}, 32'(chain_en), 32'(e_chain));
    cmp({tag, ".out_valid"}, 32'(out_valid), 32'(m_pend));
    if (!rst_n) begin
      d = 0; ph = 0;
    end else if (m_dump) begin
      d = m_d; ph = m_d;
    end else if (m_cnt == 0) begin
      d = int'(decim); ph = 0;
    end else begin
      d = m_d; ph = m_cnt;
    end
    for (int k = 0; k < NM; k++) begin
      cmp($sformatf("%s.addr%0d", tag, k), 32'(coef_addr[k*AW +: AW]),
          32'((k * (d + 1) + ph) % (1 << AW)));
    end
`ifdef NYQ_CTRL_FRAMECNT_EN
    cmp({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(m_frames % 65536));
`else
    cmp({tag, ".frame_cnt"}, 32'(frame_cnt), 32'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_dump) begin
        if (e_chain) begin
          m_dump = 0;
          m_cnt  = 0;
        end
      end else if (m_cnt > 0 && !en) begin
        m_cnt = 0;
      end else if (e_acc) begin
        if (m_cnt == 0) m_d = int'(decim);
        m_cnt++;
        if (m_cnt == m_d + 1) m_dump = 1;
      end
      if (e_chain) begin
        m_pend = 1;
        m_frames++;
      end else if (m_pend && out_ready) begin
        m_pend = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    #1;
    check(tag);
    tick();
  endtask

  initial begin
    int budget;
    model_reset();
    rst_n = 1'b0; en = 1'b1; valid = 1'b1; out_ready = 1'b0; decim = 3'd5;
    #3;
    check("reset");
    @(negedge clk);
    step("reset_hold");
    rst_n = 1'b1;

    // Continuous frames with D = 7.
    decim = 3'd7; en = 1'b1; valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 30; i++) step("d7");

    // D = 0: every sample is a whole frame.
    while (m_cnt != 0 || m_dump) step("d7_drain");
    decim = 3'd0;
    for (int i = 0; i < 12; i++) step("d0");

    // Backpressure: stall the second frame in dump.
    decim = 3'd3; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) step("stall");
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step("release");

    // Abort after 3 of 8 samples while an output is pending.
    decim = 3'd7; out_ready = 1'b0;
    budget = 60;
    while (!(m_cnt == 3 && m_pend) && budget > 0) begin
      step("abort_fill");
      budget--;
    end
    cmp("abort_reached", 32'(m_cnt == 3 && m_pend), 32'd1);
    en = 1'b0;
    step("abort0");
    step("abort1");
    en = 1'b1;
    for (int i = 0; i < 3; i++) step("abort_restart");
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step("abort_deliver");

    // Asynchronous reset at phase 5.
    decim = 3'd7;
    budget = 40;
    while (!(m_cnt == 5 && !m_dump) && budget > 0) begin
      step("pre_rst");
      budget--;
    end
    cmp("rst_point_reached", 32'(m_cnt == 5 && !m_dump), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step("post_rst");

    // Randomized traffic; mid-frame factor changes must be ignored.
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 15) != 0);
      valid     = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      decim     = CW'($urandom_range(0, (1 << CW) - 1));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nyq_seq_ctrl.md
# nyq_seq_ctrl

Sequencer for the polyphase Nyquist decimation datapath. It accepts input samples over a valid/ready handshake and counts decimation phases. Each cycle it drives one coefficient-memory address per MAC lane, plus the MAC clear/enable and partial-sum chain capture strobes. It presents each decimated output with a valid/ready handshake and applies backpressure upstream when the output slot is occupied.

## Interface
- CNT_WIDTH, 3: phase counter width; decimation factor up to 2^CNT_WIDTH
- NUM_MAC, 4: number of MAC lanes in the datapath
- ADDR_WIDTH, 9: coefficient memory address width
- Clk_CI  in  1  clock
- Rst_RBI  in  1  reset, asynchronous, active-low
- En_SI  in  1  run enable; low holds/aborts sequencing (e.g. during parameter writes)
- Decim_DI  in  CNT_WIDTH  decimation factor minus one (D); sampled at frame start
- InValid_SI  in  1  input sample valid
- InReady_SO  out  1  input sample accepted when InValid_SI & InReady_SO
- CoefAddr_DO  out  NUM_MAC*ADDR_WIDTH  lane k address in bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- MacEn_SO  out  1  MAC lanes consume current sample this cycle
- MacClr_SO  out  1  MAC lanes load product instead of accumulating (first phase)
- ChainEn_SO  out  1  partial-sum chain registers capture MAC results
- OutValid_SO  out  1  decimated output available
- OutReady_SI  in  1  downstream accepts output
- FrameCnt_DO  out  16  completed-frame counter (see Configuration)

## Operation
- States: IDLE, ACCUM, DUMP. Registers: state, phase (CNT_WIDTH), D_q (CNT_WIDTH), out_pend, frame count.
- IDLE:
  - InReady_SO = En_SI.
  - On accept: D_q <= Decim_DI; MacEn_SO = MacClr_SO = 1. Go to DUMP if Decim_DI == 0; else go to ACCUM with phase <= 1.
- ACCUM:
  - InReady_SO = En_SI.
  - Each accept asserts MacEn_SO (MacClr_SO = 0). If phase == D_q, go to DUMP; else phase <= phase+1.
  - Cycles without InValid_SI hold everything.
- DUMP:
  - InReady_SO = 0.
  - If out_pend & !OutReady_SI: stall in DUMP with ChainEn_SO = 0.
  - Otherwise: ChainEn_SO = 1, out_pend <= 1, phase <= 0, go to IDLE.
- Output:
  - OutValid_SO = out_pend.
  - out_pend clears on OutValid_SO & OutReady_SI unless ChainEn_SO is set the same cycle, in which case it stays 1.
- Address for lane k is k*(D+1) + phase, truncated to ADDR_WIDTH, computed combinationally:
  - In IDLE: D = Decim_DI and phase = 0.
  - Otherwise: D = D_q and the registered phase.
- En_SI low in ACCUM aborts the frame:
  - Next state is IDLE, phase <= 0, no ChainEn_SO.
  - An existing out_pend is unaffected.
- En_SI low in DUMP does not abort; the dump completes.
- Decim_DI changes mid-frame are ignored until the next IDLE accept.

## Timing
- Reset values: all state to IDLE, phase 0, D_q 0, out_pend 0.
- Reset output values: InReady_SO 0, MacEn_SO 0, MacClr_SO 0, ChainEn_SO 0, OutValid_SO 0, FrameCnt_DO 0, CoefAddr_DO = k*1 per lane.
- Reset asserted mid-frame discards the frame immediately, asynchronously.
- All strobes and CoefAddr_DO are combinational from registered state and inputs; they are valid in the same cycle as the accept.
- Latency, last sample accepted at cycle t:
  - ChainEn_SO at t+1, when the slot is free.
  - OutValid_SO from t+2 until the handshake.
- Throughput: one frame per D+2 cycles with continuous input and OutReady_SI = 1. The DUMP cycle costs one input bubble.
- Simultaneous ChainEn_SO with an output handshake: the old output is consumed, the new one becomes pending, and OutValid_SO stays 1.

## Configuration
- NYQ_CTRL_FRAMECNT_EN:
  - Defined: FrameCnt_DO is a 16-bit counter, incremented on each ChainEn_SO, wrapping 0xFFFF->0, reset to 0.
  - Undefined: FrameCnt_DO is tied to 0 and no counter register exists.

## Test plan
- Reset, then Decim_DI=7 with continuous InValid_SI and OutReady_SI=1:
  - MacClr_SO on samples 0, 8, 16.
  - ChainEn_SO one cycle after samples 7 and 15.
  - OutValid_SO 2 cycles after sample 7; one output per 9 cycles.
  - Lane 3 CoefAddr_DO = 24..31 across phases.
- Decim_DI=0:
  - Every accepted sample has MacClr_SO = MacEn_SO = 1.
  - Next cycle ChainEn_SO; InReady_SO alternates 1,0.
  - Lane addresses are 0,1,2,3.
- OutReady_SI held 0 after the first output, Decim_DI=3:
  - Second frame stalls in DUMP; InReady_SO = 0 and ChainEn_SO = 0 until OutReady_SI rises.
  - Then ChainEn_SO fires the same cycle as the handshake and OutValid_SO stays 1.
- En_SI dropped after 3 of 8 samples:
  - Returns to IDLE with no ChainEn_SO.
  - The next accept asserts MacClr_SO with phase 0.
  - A pending output is still delivered.
- Rst_RBI pulsed low mid-ACCUM at phase 5:
  - All outputs return to reset values asynchronously.
  - The next frame starts with MacClr_SO.
- With NYQ_CTRL_FRAMECNT_EN defined:
  - FrameCnt_DO = 3 after three frames.
  - Preload via 65535 frames, then verify the wrap to 0.
  - Without the macro, FrameCnt_DO stays 0.
